counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 134 +++++++++++++
 tb/tb_counter_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter: NREQ requesters share one interval counter.
// The round-robin winner holds grant for dur+1 cycles, then done pulses.
//
// Ports:
//   clk   - clock; all state changes on its rising edge
//   reset - synchronous active-high reset
//   req   - per-requester level request (bit i = requester i)
//   dur   - per-requester interval, slice [i*WIDTH +: WIDTH]
//   grant - registered one-hot grant (or zero)
//   done  - registered one-cycle completion pulse (one-hot or zero)
//   busy  - high whenever the state is not IDLE
//   count - registered interval counter value
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dur,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IW-1:0]    last;
    logic [IW-1:0]    last_n;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    gidx_n;
    logic [IW-1:0]    win;
    logic [IW-1:0]    cand;
    logic             any_req;
    logic [WIDTH-1:0] dur_lat;
    logic [WIDTH-1:0] dur_lat_n;
    logic [WIDTH-1:0] count_n;
    logic [NREQ-1:0]  grant_n;
    logic [NREQ-1:0]  done_n;

    // Round-robin search: scan from last+1 upward, wrapping, so the
    // most recently served requester is examined last.
    always_comb begin
        win     = last;
        cand    = last;
        any_req = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        state_n   = state;
        last_n    = last;
        gidx_n    = gidx;
        dur_lat_n = dur_lat;
        count_n   = count;
        grant_n   = grant;
        done_n    = '0;
        unique case (state)
            S_IDLE: begin
                grant_n = '0;
                count_n = '0;
                if (any_req) begin
                    state_n   = S_RUN;
                    gidx_n    = win;
                    grant_n   = NREQ'(1) << win;
                    dur_lat_n = dur[win*WIDTH +: WIDTH];
                end
            end
            S_RUN: begin
                // Abort outranks completion on the same edge.
                if (!req[gidx]) begin
                    state_n = S_IDLE;
                    grant_n = '0;
                    count_n = '0;
                    last_n  = gidx;
                end else if (count == dur_lat) begin
                    state_n = S_DONE;
                    grant_n = '0;
                    done_n  = NREQ'(1) << gidx;
                end else begin
                    count_n = count + WIDTH'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                last_n  = gidx;
                count_n = '0;
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            last    <= IW'(NREQ - 1);
            gidx    <= '0;
            dur_lat <= '0;
            count   <= '0;
            grant   <= '0;
            done    <= '0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            gidx    <= gidx_n;
            dur_lat <= dur_lat_n;
            count   <= count_n;
            grant   <= grant_n;
            done    <= done_n;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: scoreboard bench for counter_arbiter.
// A second small instance (NREQ=2, WIDTH=4) covers the full-scale interval.
module tb_counter_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [83:0] dur;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [20:0] count;

    logic        sreset;
    logic [1:0]  sreq;
    logic [7:0]  sdur;
    logic [1:0]  sgrant;
    logic [1:0]  sdone;
    logic        sbusy;
    logic [3:0]  scount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  g;
        logic [3:0]  d;
        logic [20:0] c;
        logic        b;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_arbiter #(.NREQ(4), .WIDTH(21)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dur   (dur),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    counter_arbiter #(.NREQ(2), .WIDTH(4)) sdut (
        .clk   (clk),
        .reset (sreset),
        .req   (sreq),
        .dur   (sdur),
        .grant (sgrant),
        .done  (sdone),
        .busy  (sbusy),
        .count (scount)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the expected post-edge outputs, advance one edge, pop, compare.
    task automatic ex(input string tag, input logic [3:0] g,
                      input logic [3:0] d, input int c, input logic b);
        exp_t e;
        exp_t o;
        e.tag = tag;
        e.g   = g;
        e.d   = d;
        e.c   = 21'(c);
        e.b   = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk({o.tag, ".grant"}, 32'(grant), 32'(o.g));
        chk({o.tag, ".done"},  32'(done),  32'(o.d));
        chk({o.tag, ".count"}, 32'(count), 32'(o.c));
        chk({o.tag, ".busy"},  32'(busy),  32'(o.b));
    endtask

    task automatic set_dur(input int i, input int v);
        dur[i*21 +: 21] = 21'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex("rst", 4'b0, 4'b0, 0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        reset  = 1'b1;
        req    = '0;
        dur    = '0;
        sreset = 1'b1;
        sreq   = '0;
        sdur   = '0;

        // Single request, interval 3.
        do_reset();
        req = 4'b0001;
        set_dur(0, 3);
        for (int c = 0; c <= 3; c++) ex("single", 4'b0001, 4'b0, c, 1'b1);
        ex("single_done", 4'b0, 4'b0001, 3, 1'b1);
        req = '0;
        ex("single_idle", 4'b0, 4'b0, 0, 1'b0);

        // Round-robin, all intervals 0.
        do_reset();
        dur = '0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            g = 4'(1 << (i % 4));
            ex("rr_grant", g, 4'b0, 0, 1'b1);
            ex("rr_done", 4'b0, g, 0, 1'b1);
            ex("rr_idle", 4'b0, 4'b0, 0, 1'b0);
        end
        req = '0;
        ex("rr_off", 4'b0, 4'b0, 0, 1'b0);

        // Abort at count 4, requester 1 waiting.
        do_reset();
        set_dur(0, 10);
        set_dur(1, 2);
        req = 4'b0011;
        for (int c = 0; c <= 4; c++) ex("abort_run", 4'b0001, 4'b0, c, 1'b1);
        req = 4'b0010;
        ex("abort", 4'b0, 4'b0, 0, 1'b0);
        for (int c = 0; c <= 2; c++) ex("r1_run", 4'b0010, 4'b0, c, 1'b1);
        ex("r1_done", 4'b0, 4'b0010, 2, 1'b1);
        req = '0;
        ex("r1_idle", 4'b0, 4'b0, 0, 1'b0);

        // Reset mid-run at count 7, then requester 0 wins over 3.
        do_reset();
        dur = '0;
        set_dur(0, 20);
        req = 4'b0001;
        for (int c = 0; c <= 7; c++) ex("mid_run", 4'b0001, 4'b0, c, 1'b1);
        reset = 1'b1;
        ex("mid_rst", 4'b0, 4'b0, 0, 1'b0);
        reset = 1'b0;
        set_dur(0, 0);
        set_dur(3, 1);
        req = 4'b1001;
        ex("post_r0", 4'b0001, 4'b0, 0, 1'b1);
        ex("post_r0_done", 4'b0, 4'b0001, 0, 1'b1);
        req = 4'b1000;
        ex("post_idle", 4'b0, 4'b0, 0, 1'b0);
        ex("post_r3", 4'b1000, 4'b0, 0, 1'b1);
        ex("post_r3", 4'b1000, 4'b0, 1, 1'b1);
        ex("post_r3_done", 4'b0, 4'b1000, 1, 1'b1);
        req = '0;
        ex("post_off", 4'b0, 4'b0, 0, 1'b0);

        // Reset release with only requester 3 asking: it wins directly.
        req = 4'b1000;
        do_reset();
        ex("only_r3", 4'b1000, 4'b0, 0, 1'b1);
        req = '0;
        ex("only_r3_abort", 4'b0, 4'b0, 0, 1'b0);

        // Input changes during RUN do not disturb requester 0.
        do_reset();
        dur = '0;
        set_dur(0, 3);
        req = 4'b0001;
        ex("stab", 4'b0001, 4'b0, 0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            set_dur(0, 9 + c);
            req[1] = ~req[1];
            ex("stab", 4'b0001, 4'b0, c, 1'b1);
        end
        ex("stab_done", 4'b0, 4'b0001, 3, 1'b1);
        req = '0;
        ex("stab_idle", 4'b0, 4'b0, 0, 1'b0);

        // Full-scale interval on the narrow instance: 16 grant cycles.
        sreset = 1'b1;
        @(posedge clk);
        #1;
        chk("s_rst.grant", 32'(sgrant), 32'd0);
        sreset = 1'b0;
        sreq   = 2'b01;
        sdur   = 8'h0F;
        for (int c = 0; c <= 15; c++) begin
            @(posedge clk);
            #1;
            chk("s_run.grant", 32'(sgrant), 32'd1);
            chk("s_run.count", 32'(scount), 32'(c));
        end
        @(posedge clk);
        #1;
        chk("s_done.done",  32'(sdone),  32'd1);
        chk("s_done.grant", 32'(sgrant), 32'd0);
        chk("s_done.count", 32'(scount), 32'd15);
        sreq = '0;
        @(posedge clk);
        #1;
        chk("s_idle.busy", 32'(sbusy), 32'd0);
        chk("s_idle.done", 32'(sdone), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
